// File: rtl/rtc_edit_controller_pkg.sv
// Shared encodings for the RTC front-panel edit controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rtc_edit_controller_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_HOUR   = 2'd1,
        MODE_DATE   = 2'd2,
        MODE_CHRONO = 2'd3
    } mode_t;

    // Highest field index (hh/mm/ss or dd/mm/yy).
    localparam logic [1:0] FIELD_MAX = 2'd2;

endpackage

// File: rtl/rtc_edit_controller_button.sv
// Edge detect plus auto-repeat pulse generation for one debounced button.
// Latency: pulse is combinational in the cycle the rise or repeat point is sampled.
// Backpressure: none; enable low or clear high drops the repeat sequence.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   level        debounced button level
//   enable       repeat generation allowed this cycle
//   clear        force the repeat sequence back to idle at the next edge
//   rise         level rose this cycle (independent of enable)
//   pulse        one-cycle command request (rise or auto-repeat point)
module button_repeat #(
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int CNT_W        = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic enable,
    input  logic clear,
    output logic rise,
    output logic pulse
);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;        // cycles since last pulse; 0 = not armed
    logic             repeating_q;  // past the first (long) repeat delay
    logic             armed;
    logic             due;

    assign rise  = level & ~prev_q;
    assign armed = (cnt_q != '0);
    assign due   = armed && (repeating_q ? (cnt_q == CNT_W'(REPEAT_RATE))
                                         : (cnt_q == CNT_W'(REPEAT_DELAY)));
    assign pulse = enable & level & (rise | due);

    always_ff @(posedge clk) begin
        if (reset) begin
            // Ones so a button held through reset yields no rise.
            prev_q      <= 1'b1;
            cnt_q       <= '0;
            repeating_q <= 1'b0;
        end else begin
            prev_q <= level;
            if (clear || !enable || !level) begin
                cnt_q       <= '0;
                repeating_q <= 1'b0;
            end else if (rise) begin
                cnt_q       <= CNT_W'(1);
                repeating_q <= 1'b0;
            end else if (due) begin
                cnt_q       <= CNT_W'(1);
                repeating_q <= 1'b1;
            end else if (armed) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_edit_controller.sv
// Front-panel sequencer: edit-mode FSM, field cursor, inc/dec commands with auto-repeat.
// Latency: every output is registered, responding one edge after the sampled rise.
// Backpressure: none; commands are fire-and-forget single-cycle pulses.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   au, dis, l, r, f      debounced up/down/left/right/format levels
//   prh, prf, prc, icr    debounced program hour/date/chrono and chrono start levels
//   mode, field           current edit context and selected field
//   inc_pulse, dec_pulse  one-cycle increment/decrement commands
//   fmt_12h, chrono_run   format and chronometer run levels
module rtc_edit_controller
    import rtc_edit_controller_pkg::*;
#(
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int TIMEOUT      = 1000000000,
    parameter int CNT_W        = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       au,
    input  logic       dis,
    input  logic       l,
    input  logic       r,
    input  logic       f,
    input  logic       prh,
    input  logic       prf,
    input  logic       prc,
    input  logic       icr,
    output logic [1:0] mode,
    output logic [1:0] field,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       fmt_12h,
    output logic       chrono_run
);

    mode_t            state_q;
    logic [CNT_W-1:0] tcnt_q;
    logic [6:0]       lvl, prev_q, rise;
    logic             l_rise, r_rise, f_rise, prh_rise, prf_rise, prc_rise, icr_rise;
    logic             au_rise, dis_rise, up_pulse, dn_pulse;
    logic             edit, rep_en, any_rise, same_rise, timeout_hit, leaving;

    assign lvl      = {icr, prc, prf, prh, f, r, l};
    assign rise     = lvl & ~prev_q;
    assign l_rise   = rise[0];
    assign r_rise   = rise[1];
    assign f_rise   = rise[2];
    assign prh_rise = rise[3];
    assign prf_rise = rise[4];
    assign prc_rise = rise[5];
    assign icr_rise = rise[6];

    assign edit   = (state_q != MODE_IDLE);
    // Up and down together is treated as neither: no pulses, counters parked.
    assign rep_en = edit & ~(au & dis);

    button_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)
    ) u_up (
        .clk(clk), .reset(reset), .level(au), .enable(rep_en), .clear(leaving),
        .rise(au_rise), .pulse(up_pulse)
    );

    button_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)
    ) u_dn (
        .clk(clk), .reset(reset), .level(dis), .enable(rep_en), .clear(leaving),
        .rise(dis_rise), .pulse(dn_pulse)
    );

    assign any_rise = (|rise) | au_rise | dis_rise;

    always_comb begin
        same_rise = 1'b0;
        case (state_q)
            MODE_HOUR:   same_rise = prh_rise;
            MODE_DATE:   same_rise = prf_rise;
            MODE_CHRONO: same_rise = prc_rise;
            default:     same_rise = 1'b0;
        endcase
    end

    // Any activity this cycle (rise or auto-repeat) beats an expiring timeout.
    assign timeout_hit = edit && (tcnt_q == CNT_W'(TIMEOUT - 1)) &&
                         !any_rise && !up_pulse && !dn_pulse;
    assign leaving     = edit && (same_rise || timeout_hit);

    assign mode = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MODE_IDLE;
            field      <= 2'd0;
            inc_pulse  <= 1'b0;
            dec_pulse  <= 1'b0;
            fmt_12h    <= 1'b0;
            chrono_run <= 1'b0;
            tcnt_q     <= '0;
            prev_q     <= '1;
        end else begin
            prev_q    <= lvl;
            inc_pulse <= up_pulse & ~leaving;
            dec_pulse <= dn_pulse & ~leaving;

            if (f_rise && (state_q == MODE_IDLE || state_q == MODE_HOUR))
                fmt_12h <= ~fmt_12h;

            if (!edit || any_rise || up_pulse || dn_pulse || timeout_hit)
                tcnt_q <= '0;
            else
                tcnt_q <= tcnt_q + CNT_W'(1);

            case (state_q)
                MODE_IDLE: begin
                    if (icr_rise)
                        chrono_run <= ~chrono_run;
                    if (prh_rise) begin
                        state_q <= MODE_HOUR;
                        field   <= 2'd0;
                    end else if (prf_rise) begin
                        state_q <= MODE_DATE;
                        field   <= 2'd0;
                    end else if (prc_rise) begin
                        state_q    <= MODE_CHRONO;
                        field      <= 2'd0;
                        chrono_run <= 1'b0;  // overrides a same-cycle icr toggle
                    end
                end
                default: begin
                    if (leaving) begin
                        state_q <= MODE_IDLE;
                        field   <= 2'd0;
                    end else if (l_rise && !r_rise) begin
                        field <= (field == 2'd0) ? FIELD_MAX : field - 2'd1;
                    end else if (r_rise && !l_rise) begin
                        field <= (field == FIELD_MAX) ? 2'd0 : field + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
